// File: rtl/serial_sub_pkg.sv
// Shared types and the full-subtractor bit function for the bit-serial
// subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // One full-subtractor step: returns {difference bit, borrow-out}.
    function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic br);
        logic d;
        logic br_next;
        d       = a ^ b ^ br;
        br_next = (~a & b) | (~(a ^ b) & br);
        return {d, br_next};
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// Combinational single-bit full subtractor used by the serial datapath.
module full_sub_cell
    import serial_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign {d, bout} = fs_bit(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_next;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             cell_d;
    logic             cell_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_sub_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New result bit enters at the MSB while the older bits move toward the LSB.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        diff_next            = diff >> 1;
        diff_next[WIDTH-1]   = cell_d;
    end

    // Control FSM, operand shift registers, counter and borrow flop.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            cnt   <= '0;
            br    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        ovf   <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    diff <= diff_next;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= cell_bout;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        bout  <= cell_bout;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized
// operands compared against an arithmetic reference (a - b - bin mod 2^W).
// Optional overflow checks compile in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         start8 = 1'b0;
    logic [W-1:0] a8 = '0, b8 = '0;
    logic         bin8 = 1'b0;
    logic         busy8, done8, bout8;
    logic [W-1:0] diff8;

    logic         start1 = 1'b0;
    logic [0:0]   a1 = '0, b1 = '0;
    logic         bin1 = 1'b0;
    logic         busy1, done1, bout1;
    logic [0:0]   diff1;

`ifdef SERIAL_SUB_OVF_EN
    logic         ovf8, ovf1;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: modulo-2^W difference, unsigned borrow, signed overflow rule.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int unsigned r;
        r = (int'(a) - int'(b) - int'(bin)) & ((1 << W) - 1);
        return r[W-1:0];
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        return int'(a) < (int'(b) + int'(bin));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W-1:0] d;
        d = ref_diff(a, b, bin);
        return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    endfunction

    // Launch one 8-bit operation and wait for done; checks latency, result
    // and that done is exactly one cycle wide.
    task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input string tag);
        int n;
        logic [W-1:0] exp_d;
        exp_d = ref_diff(a, b, bin);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; bin8 = ~bin;   // operands may change after acceptance
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done8) break;
        end
        check({tag, "_latency"}, n, W);
        check({tag, "_diff"}, diff8, exp_d);
        check({tag, "_bout"}, bout8, ref_bout(a, b, bin));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf8, ref_ovf(a, b, bin));
`endif
        @(posedge clk); #1;
        check({tag, "_done_width"}, done8, 1'b0);
        check({tag, "_diff_hold"}, diff8, exp_d);
    endtask

    initial begin
        int n;
        logic saw_done;
        logic [W-1:0] ra, rb;
        logic rbin;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy8, 1'b0);
        check("reset_done", done8, 1'b0);
        check("reset_diff", diff8, 0);
        check("reset_bout", bout8, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        op8(8'h05, 8'h03, 1'b0, "t1");
        op8(8'h00, 8'h01, 1'b0, "t2a");
        op8(8'h10, 8'h0F, 1'b1, "t2b");
        op8(8'h80, 8'h01, 1'b0, "ovf_a");
        op8(8'h7F, 8'hFF, 1'b0, "ovf_b");
        op8(8'hFF, 8'hFF, 1'b1, "all_ones_bin");

        // Start pulse during an operation is ignored; busy stays high.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("t3_busy", busy8, 1'b1);
        end
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 4;
        while (!done8 && n < 40) begin
            check("t3_busy", busy8, 1'b1);
            @(posedge clk); #1;
            n++;
        end
        check("t3_latency", n, W);
        check("t3_diff", diff8, ref_diff(8'h5A, 8'h33, 1'b0));
        check("t3_bout", bout8, ref_bout(8'h5A, 8'h33, 1'b0));
        // Start held through DONE must not launch a new operation.
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("t3_done_start_ignored", busy8, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t4_busy", busy8, 1'b0);
        check("t4_done", done8, 1'b0);
        check("t4_diff", diff8, 0);
        check("t4_bout", bout8, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("t4_ovf", ovf8, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) saw_done = 1'b1;
        end
        check("t4_no_done", saw_done, 1'b0);
        op8(8'h42, 8'h24, 1'b1, "t4_after");

        // WIDTH=1: full subtractor truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic ea, eb, ebin;
            v = 3'(i);
            ea = v[2]; eb = v[1]; ebin = v[0];
            @(negedge clk);
            a1 = ea; b1 = eb; bin1 = ebin; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            n = 0;
            while (n < 10) begin
                @(posedge clk); #1;
                n++;
                if (done1) break;
            end
            check("w1_latency", n, 1);
            check("w1_diff", diff1, (int'(ea) - int'(eb) - int'(ebin)) & 1);
            check("w1_bout", bout1, int'(ea) < int'(eb) + int'(ebin));
            @(posedge clk); #1;
        end

        // Randomized operands with random idle gaps.
        for (int k = 0; k < 40; k++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            op8(ra, rb, rbin, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
